// File: rtl/seq_decimal_formatter_if.sv
// Handshake bundle for the signed-binary to BCD formatter.
// The master drives values in and drains results; the slave is the converter.
interface seq_decimal_formatter_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10,
  parameter int CNT_W  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_value;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_neg;
  logic [4*DIGITS-1:0]   out_bcd;
  logic [CNT_W-1:0]      out_ndigits;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_neg, out_bcd, out_ndigits
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_neg, out_bcd, out_ndigits
  );
endinterface

// File: rtl/seq_decimal_formatter.sv
// Sequential signed-binary to BCD converter (double-dabble, one bit per cycle).
// Accepts a two's-complement value, converts its magnitude to packed BCD and
// reports sign plus significant-digit count. All outputs are registered.
module seq_decimal_formatter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_decimal_formatter_if.slave bus
);

  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  logic [BIT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   mag_r;
  logic [BCD_W-1:0]   bcd_r;
  logic               sign_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               out_neg_r;
  logic [BCD_W-1:0]   out_bcd_r;
  logic [CNT_W-1:0]   out_ndigits_r;

  logic [BCD_W-1:0]        bcd_adj_s;
  logic [BCD_W+WIDTH-1:0]  shift_s;
  logic [BCD_W-1:0]        bcd_next_s;
  logic [WIDTH-1:0]        mag_next_s;

  // Add 3 to every nibble >= 5 so the following left shift carries correctly.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic [3:0]       nib;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = b[4*i +: 4];
      if (nib >= 4'd5) begin
        r[4*i +: 4] = nib + 4'd3;
      end else begin
        r[4*i +: 4] = nib;
      end
    end
    return r;
  endfunction

  // One plus the index of the highest nonzero nibble; zero still shows one digit.
  function automatic logic [CNT_W-1:0] count_digits(input logic [BCD_W-1:0] b);
    logic [CNT_W-1:0] n;
    n = CNT_W'(1);
    for (int i = 1; i < DIGITS; i++) begin
      if (b[4*i +: 4] != 4'd0) begin
        n = CNT_W'(i + 1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Magnitude of a two's-complement value; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    if (v[WIDTH-1]) begin
      m = ~v + WIDTH'(1);
    end else begin
      m = v;
    end
    return m;
  endfunction

  assign bcd_adj_s  = add3_nibbles(bcd_r);
  assign shift_s    = {bcd_adj_s, mag_r} << 1;
  assign bcd_next_s = shift_s[BCD_W+WIDTH-1:WIDTH];
  assign mag_next_s = shift_s[WIDTH-1:0];

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_neg     = out_neg_r;
  assign bus.out_bcd     = out_bcd_r;
  assign bus.out_ndigits = out_ndigits_r;

  // Control FSM and datapath: capture, WIDTH shift-add-3 steps, hold result until drained.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      mag_r         <= '0;
      bcd_r         <= '0;
      sign_r        <= 1'b0;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      out_neg_r     <= 1'b0;
      out_bcd_r     <= '0;
      out_ndigits_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          if (bus.in_valid && in_ready_r) begin
            sign_r     <= bus.in_value[WIDTH-1];
            mag_r      <= magnitude(bus.in_value);
            bcd_r      <= '0;
            cnt_r      <= BIT_W'(WIDTH);
            in_ready_r <= 1'b0;
            state_r    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_r <= bcd_next_s;
          mag_r <= mag_next_s;
          cnt_r <= cnt_r - BIT_W'(1);
          if (cnt_r == BIT_W'(1)) begin
            out_bcd_r     <= bcd_next_s;
            out_neg_r     <= sign_r;
            out_ndigits_r <= count_digits(bcd_next_s);
            out_valid_r   <= 1'b1;
            state_r       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_decimal_formatter.sv
// Scoreboard bench for seq_decimal_formatter: the stimulus pushes hand-computed
// results on accept, a monitor pops and compares on every output handshake.
module tb_seq_decimal_formatter;

  logic clk;
  logic rst;

  seq_decimal_formatter_if #(.WIDTH(32), .DIGITS(10), .CNT_W(4)) bus ();

  seq_decimal_formatter #(.WIDTH(32), .DIGITS(10), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        neg;
    logic [39:0] bcd;
    logic [3:0]  nd;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every completed output handshake against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got bcd %0h with no pending expectation", bus.out_bcd);
      end else begin
        e = exp_q.pop_front();
        chk("sb_neg", bus.out_neg, e.neg);
        chk("sb_bcd", bus.out_bcd, e.bcd);
        chk("sb_ndigits", bus.out_ndigits, e.nd);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic send(input logic [31:0] v, input logic eneg, input logic [39:0] ebcd,
                      input logic [3:0] end_d);
    exp_t e;
    int   k;
    k = 0;
    while (!bus.in_ready && k < 80) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    bus.in_valid = 1'b1;
    bus.in_value = v;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    e.neg = eneg;
    e.bcd = ebcd;
    e.nd  = end_d;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    int lat;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) break;
    end
    chk(name, lat, 32);
  endtask

  task automatic after_handshake(input string name);
    @(posedge clk); #1;
    chk({name, "_valid_drop"}, bus.out_valid, 1'b0);
    chk({name, "_ready_back"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    int seen;
    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_value  = 32'd0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_neg", bus.out_neg, 1'b0);
    chk("rst_out_bcd", bus.out_bcd, 40'h0);
    chk("rst_out_nd", bus.out_ndigits, 4'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);

    // Single conversions with out_ready held high.
    send(32'd0, 1'b0, 40'h0000000000, 4'd1);
    wait_valid("lat_zero");
    after_handshake("zero");
    send(32'd123, 1'b0, 40'h0000000123, 4'd3);
    wait_valid("lat_123");
    after_handshake("v123");

    // Negative and positive extremes.
    send(32'hFFFFFFFF, 1'b1, 40'h0000000001, 4'd1);
    wait_valid("lat_m1");
    after_handshake("m1");
    send(32'h80000000, 1'b1, 40'h2147483648, 4'd10);
    wait_valid("lat_min");
    after_handshake("min");
    send(32'h7FFFFFFF, 1'b0, 40'h2147483647, 4'd10);
    wait_valid("lat_max");
    after_handshake("max");

    // Backpressure: hold the result for 5 cycles.
    bus.out_ready = 1'b0;
    send(32'd40960, 1'b0, 40'h0000040960, 4'd5);
    wait_valid("lat_bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_bcd", bus.out_bcd, 40'h0000040960);
      chk("bp_nd", bus.out_ndigits, 4'd5);
      chk("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    after_handshake("bp");

    // Input presented while busy is ignored.
    send(32'd7, 1'b0, 40'h0000000007, 4'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_value = 32'd99;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("busy_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    seen = 0;
    while (!bus.out_valid && seen < 60) begin
      @(posedge clk); #1;
      seen++;
    end
    chk("busy_done", bus.out_valid, 1'b1);
    after_handshake("busy");
    send(32'd99, 1'b0, 40'h0000000099, 4'd2);
    wait_valid("lat_99");
    after_handshake("v99");

    // Reset in the middle of a conversion of -500.
    send(32'hFFFFFE0C, 1'b1, 40'h0000000500, 4'd3);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_bcd", bus.out_bcd, 40'h0);
    chk("mid_rst_neg", bus.out_neg, 1'b0);
    chk("mid_rst_nd", bus.out_ndigits, 4'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk("mid_rst_in_ready", bus.in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("mid_rst_no_result", seen, 0);
    send(32'd500, 1'b0, 40'h0000000500, 4'd3);
    wait_valid("lat_500");
    after_handshake("v500");

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_decimal_formatter.md
Name: seq_decimal_formatter

Overview:
- Sequential signed-binary to BCD converter that sits upstream of the on-board number display.
- Accepts a 32-bit two's-complement value over a valid/ready handshake.
- Converts the magnitude to 10 BCD digits with an iterative shift-add-3 (double-dabble) datapath, one bit per cycle.
- Presents sign, packed digits and significant-digit count over a second valid/ready handshake, in place of a combinational divide-by-10 chain.

Parameters:
- WIDTH, 32, input value width in bits (two's complement).
- DIGITS, 10, number of BCD output digits; must satisfy 10^DIGITS > 2^(WIDTH-1).
- CNT_W, 4, width of out_ndigits; must hold DIGITS.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); released synchronously by the environment.
- in_valid  in  1  in_value holds a value to convert.
- in_ready  out  1  block can accept a value this cycle.
- in_value  in  WIDTH  signed value to convert.
- out_valid  out  1  result registers hold a completed conversion.
- out_ready  in  1  consumer accepts the result this cycle.
- out_neg  out  1  1 when the accepted value was negative.
- out_bcd  out  4*DIGITS  packed BCD magnitude; digit 0 (units) in bits [3:0].
- out_ndigits  out  CNT_W  count of significant digits, 1..DIGITS; 1 for zero.

Behaviour:
- Reset (rst=0) asynchronously forces:
  - state IDLE;
  - out_valid=0, out_neg=0, out_bcd=0, out_ndigits=0;
  - bit counter=0, shift and BCD working registers=0.
- in_ready is 1 in the first cycle after reset.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture sign = in_value[WIDTH-1].
  - Capture magnitude = sign ? (~in_value+1) : in_value, treated as WIDTH-bit unsigned. -2^31 therefore yields 2147483648.
  - Clear the BCD accumulator, load bit counter = WIDTH, go to SHIFT.
- State SHIFT:
  - in_ready=0, out_valid=0.
  - Each cycle, first add 3 to every BCD nibble >= 5.
  - Then shift {bcd, magnitude} left by 1; the magnitude MSB enters BCD bit 0.
  - Decrement the bit counter.
  - When the counter reaches 1 this cycle, perform the final shift and go to DONE.
- Transition into DONE, all registered on the same edge:
  - out_bcd = final BCD;
  - out_neg = captured sign;
  - out_ndigits = 1 + index of the highest nonzero nibble (1 if all zero);
  - out_valid=1.
- State DONE:
  - in_ready=0.
  - out_valid stays 1, and out_neg/out_bcd/out_ndigits stay stable until out_ready=1.
  - On out_valid&&out_ready: out_valid goes to 0 next cycle and the state returns to IDLE. Data outputs keep their last values.
- Latency: an input accepted at edge N gives out_valid=1 after edge N+WIDTH (32 cycles for WIDTH=32).
- Throughput: one conversion per WIDTH+2 cycles with out_ready held high.
- in_valid asserted outside IDLE is ignored, and in_value is not sampled.
- Nibble values never exceed 9 at any observable output.
- Reset mid-SHIFT or mid-DONE: the conversion is aborted, no result is produced, and all outputs return to reset values.
- out_ready while out_valid=0 has no effect.
- Negative zero is impossible: out_neg=1 implies magnitude >= 1.

Test Plan:
- Single conversions, out_ready=1:
  - in_value=0 -> out_neg=0, out_bcd=0x0000000000, out_ndigits=1, 32 cycles after accept.
  - in_value=123 -> out_bcd=0x0000000123, out_ndigits=3.
- Negative extremes:
  - in_value=0xFFFFFFFF (-1) -> out_neg=1, out_bcd=0x0000000001, out_ndigits=1.
  - in_value=0x80000000 -> out_neg=1, out_bcd=0x2147483648, out_ndigits=10.
  - in_value=0x7FFFFFFF -> out_neg=0, out_bcd=0x2147483647, out_ndigits=10.
- Backpressure:
  - Convert 40960, hold out_ready=0 for 5 cycles after out_valid.
  - Required: outputs stable at 0x0000040960, nd=5; in_ready=0 throughout.
  - Raise out_ready: out_valid drops next cycle and in_ready=1.
- Input ignored while busy:
  - Accept 7, then drive in_valid=1 with 99 during SHIFT.
  - Required: result 0x0000000007; 99 is not converted until re-presented in IDLE.
- Reset mid-conversion:
  - Accept -500, assert rst=0 at cycle 10 of SHIFT.
  - Required: out_valid=0, outputs zero, in_ready=1 after release.
  - A subsequent 500 then converts to out_neg=0, 0x0000000500, nd=3.
